// File: rtl/sqrt_arbiter.sv
// ---------------------------------------------------------------------------
// sqrt_arbiter
//
// Round-robin arbiter and sequencer that shares a single sqrt unit between
// NREQ requesters. In IDLE it grants one request, latching that requester's
// operand. It then pulses sq_start for one cycle (LAUNCH) and waits for
// sq_ready (WAIT). Finally it returns the root, the flags and the requester
// index, together with a one-cycle one-hot done pulse (RESP).
//
// Optional feature macro: SQRT_ARB_TIMEOUT_EN
//   When defined, a watchdog counts WAIT cycles. After TIMEOUT_CYCLES cycles
//   without sq_ready the operation is aborted and reported with rsp_err = 1.
//   The result and both flags read 0 in that case. When the macro is
//   undefined, WAIT lasts until sq_ready and rsp_err is constant 0.
//
// Parameters:
//   NREQ           number of requesters (2..8)
//   IDW            width of rsp_id, equal to ceil(log2(NREQ))
//   TIMEOUT_CYCLES watchdog limit in WAIT (used only with the macro)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   req        in   per-requester request, held until its done bit is seen
//   req_nr     in   operands; requester i uses bits [32*i+31:32*i]
//   done       out  one-hot, one-cycle completion pulse
//   rsp_result out  root of the completed operation
//   rsp_cflag  out  Cflag of the completed operation
//   rsp_oflag  out  Oflag of the completed operation
//   rsp_err    out  watchdog abort flag
//   rsp_id     out  index of the completed requester
//   busy       out  high in every state except IDLE
//   sq_start   out  one-cycle start to the sqrt unit
//   sq_nr      out  operand to the sqrt unit, stable from LAUNCH through WAIT
//   sq_ready   in   result-valid from the sqrt unit
//   sq_result  in   root from the sqrt unit
//   sq_cflag   in   Cflag from the sqrt unit
//   sq_oflag   in   Oflag from the sqrt unit
// ---------------------------------------------------------------------------
module sqrt_arbiter #(
    parameter int NREQ           = 4,
    parameter int IDW            = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_nr,
    output logic [NREQ-1:0]      done,
    output logic [15:0]          rsp_result,
    output logic                 rsp_cflag,
    output logic                 rsp_oflag,
    output logic                 rsp_err,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic                 sq_start,
    output logic [31:0]          sq_nr,
    input  logic                 sq_ready,
    input  logic [15:0]          sq_result,
    input  logic                 sq_cflag,
    input  logic                 sq_oflag
);

    // Reject illegal parameter combinations at elaboration time.
    generate
        if ((NREQ < 2) || (NREQ > 8) || (IDW != $clog2(NREQ)) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
            $error("sqrt_arbiter: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_r;
    logic [IDW-1:0]      ptr_r;
    logic [IDW-1:0]      cur_id_r;
    logic [31:0]         sq_nr_r;
    logic                sq_start_r;
    logic                busy_r;
    logic [NREQ-1:0]     done_r;
    logic [15:0]         rsp_result_r;
    logic                rsp_cflag_r;
    logic                rsp_oflag_r;
    logic [IDW-1:0]      rsp_id_r;

    logic                grant_valid_s;
    logic [IDW-1:0]      grant_idx_s;
    logic [31:0]         grant_nr_s;
    logic [IDW:0]        sum_s;
    logic [IDW-1:0]      cand_s;
    logic                hit_s;
    logic [IDW-1:0]      ptr_next_s;
    logic [NREQ-1:0]     done_set_s;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]       tmo_cnt_r;
    logic                rsp_err_r;
`endif

    // Round-robin pick: offsets are scanned from farthest to nearest, so the
    // set request closest to ptr (with wrap-around) is the last assignment.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {IDW{1'b0}};
        sum_s         = {(IDW+1){1'b0}};
        cand_s        = {IDW{1'b0}};
        hit_s         = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum_s  = {1'b0, ptr_r} + (IDW+1)'(k);
            cand_s = (sum_s >= (IDW+1)'(NREQ)) ? IDW'(sum_s - (IDW+1)'(NREQ)) : IDW'(sum_s);
            hit_s  = req[cand_s];
            grant_valid_s = grant_valid_s | hit_s;
            grant_idx_s   = hit_s ? cand_s : grant_idx_s;
        end
    end

    // Operand multiplexer driven by the winning index.
    always_comb begin
        grant_nr_s = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            grant_nr_s = grant_nr_s | ({32{grant_idx_s == IDW'(i)}} & req_nr[32*i +: 32]);
        end
    end

    assign ptr_next_s = (cur_id_r == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (cur_id_r + IDW'(1));
    assign done_set_s = {{(NREQ-1){1'b0}}, 1'b1} << cur_id_r;

    // Sequencer FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= {IDW{1'b0}};
            cur_id_r     <= {IDW{1'b0}};
            sq_nr_r      <= 32'd0;
            sq_start_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= {NREQ{1'b0}};
            rsp_result_r <= 16'd0;
            rsp_cflag_r  <= 1'b0;
            rsp_oflag_r  <= 1'b0;
            rsp_id_r     <= {IDW{1'b0}};
`ifdef SQRT_ARB_TIMEOUT_EN
            tmo_cnt_r    <= {TW{1'b0}};
            rsp_err_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= {NREQ{1'b0}};
                    if (grant_valid_s) begin
                        cur_id_r   <= grant_idx_s;
                        sq_nr_r    <= grant_nr_s;
                        sq_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_LAUNCH;
                    end else begin
                        sq_start_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    sq_start_r <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
                    tmo_cnt_r  <= {TW{1'b0}};
`endif
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sq_ready) begin
                        rsp_result_r <= sq_result;
                        rsp_cflag_r  <= sq_cflag;
                        rsp_oflag_r  <= sq_oflag;
                        rsp_id_r     <= cur_id_r;
                        done_r       <= done_set_s;
`ifdef SQRT_ARB_TIMEOUT_EN
                        rsp_err_r    <= 1'b0;
`endif
                        state_r      <= ST_RESP;
                    end
`ifdef SQRT_ARB_TIMEOUT_EN
                    // Counter holds the number of WAIT cycles already spent.
                    else if (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_result_r <= 16'd0;
                        rsp_cflag_r  <= 1'b0;
                        rsp_oflag_r  <= 1'b0;
                        rsp_id_r     <= cur_id_r;
                        rsp_err_r    <= 1'b1;
                        done_r       <= done_set_s;
                        state_r      <= ST_RESP;
                    end else begin
                        tmo_cnt_r    <= tmo_cnt_r + TW'(1);
                        state_r      <= ST_WAIT;
                    end
`else
                    else begin
                        state_r      <= ST_WAIT;
                    end
`endif
                end
                ST_RESP: begin
                    done_r  <= {NREQ{1'b0}};
                    ptr_r   <= ptr_next_s;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r     <= {NREQ{1'b0}};
                    sq_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign done       = done_r;
    assign rsp_result = rsp_result_r;
    assign rsp_cflag  = rsp_cflag_r;
    assign rsp_oflag  = rsp_oflag_r;
    assign rsp_id     = rsp_id_r;
    assign busy       = busy_r;
    assign sq_start   = sq_start_r;
    assign sq_nr      = sq_nr_r;
`ifdef SQRT_ARB_TIMEOUT_EN
    assign rsp_err    = rsp_err_r;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sqrt_arbiter
//
// Directed bench for sqrt_arbiter with a behavioural sqrt unit of 5-cycle
// latency. The unit samples start at a rising edge and raises ready five
// cycles later. Its Cflag is operand bit 31. Its Oflag marks positive
// operands >= 2^30. The root of a negative operand reads 0.
// ---------------------------------------------------------------------------
module tb_sqrt_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [32*NREQ-1:0]  req_nr;
    logic [NREQ-1:0]     done;
    logic [15:0]         rsp_result;
    logic                rsp_cflag;
    logic                rsp_oflag;
    logic                rsp_err;
    logic [IDW-1:0]      rsp_id;
    logic                busy;
    logic                sq_start;
    logic [31:0]         sq_nr;
    logic                sq_ready;
    logic [15:0]         sq_result;
    logic                sq_cflag;
    logic                sq_oflag;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sqrt_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_nr(req_nr), .done(done),
        .rsp_result(rsp_result), .rsp_cflag(rsp_cflag), .rsp_oflag(rsp_oflag),
        .rsp_err(rsp_err), .rsp_id(rsp_id), .busy(busy), .sq_start(sq_start),
        .sq_nr(sq_nr), .sq_ready(sq_ready), .sq_result(sq_result),
        .sq_cflag(sq_cflag), .sq_oflag(sq_oflag)
    );

    // ---------------- behavioural sqrt unit ----------------
    logic m_pend;
    int   m_cnt;
    logic m_hang = 1'b0;

    function automatic logic [15:0] isqrt(input logic [31:0] n);
        longint r = 0;
        if (n[31]) return 16'd0;
        while ((r + 1) * (r + 1) <= longint'(n)) r++;
        return r[15:0];
    endfunction

    assign sq_ready = m_pend && (m_cnt == 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend <= 1'b0; m_cnt <= 0;
            sq_result <= 16'd0; sq_cflag <= 1'b0; sq_oflag <= 1'b0;
        end else if (sq_start && !m_hang) begin
            m_pend    <= 1'b1;
            m_cnt     <= 4;
            sq_result <= isqrt(sq_nr);
            sq_cflag  <= sq_nr[31];
            sq_oflag  <= !sq_nr[31] && (sq_nr >= 32'h4000_0000);
        end else if (m_pend && m_cnt == 0) begin
            m_pend <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns the cycle index (1 = first negedge after the call) of the first done.
    task automatic wait_done(input int budget, output logic [NREQ-1:0] d, output int cycles);
        d = '0; cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done != 4'b0000) begin
                d = done; cycles = i;
                break;
            end
        end
        check_eq("done_within_budget", 32'(cycles != 0), 32'd1);
    endtask

    task automatic reset_dut(input logic [NREQ-1:0] r);
        rst = 1'b0;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        req = r;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [NREQ-1:0] d;
        int              lat;
        int              prev;
        logic [3:0]      exp_one;
        logic [15:0]     exp_res [4];
        int              fair_ids [4];
        int              n_done;
        int              n_idle;

        rst = 1'b0; req = 4'b0000; req_nr = '0;
        exp_res  = '{16'd0, 16'd1, 16'd255, 16'd46340};
        fair_ids = '{0, 2, 0, 2};

        // Reset state
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_start", 32'(sq_start), 32'd0);
        check_eq("rst_nr", sq_nr, 32'd0);
        check_eq("rst_result", 32'(rsp_result), 32'd0);
        check_eq("rst_err", 32'(rsp_err), 32'd0);

        // Single request: operand 144
        reset_dut(4'b0000);
        req_nr[31:0] = 32'd144;
        req = 4'b0001;
        @(negedge clk);
        check_eq("single_start", 32'(sq_start), 32'd1);
        check_eq("single_busy", 32'(busy), 32'd1);
        check_eq("single_nr", sq_nr, 32'd144);
        wait_done(40, d, lat);
        check_eq("single_latency", 32'(lat + 1), 32'd7);
        check_eq("single_done", 32'(d), 32'h1);
        check_eq("single_result", 32'(rsp_result), 32'd12);
        check_eq("single_id", 32'(rsp_id), 32'd0);
        check_eq("single_cflag", 32'(rsp_cflag), 32'd0);
        check_eq("single_err", 32'(rsp_err), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        check_eq("single_done_pulse", 32'(done), 32'd0);
        check_eq("single_busy_fall", 32'(busy), 32'd0);
        check_eq("single_hold", 32'(rsp_result), 32'd12);

        // Full contention: all four requesters from reset release
        req_nr = {32'h7FFF_FFFE, 32'd65535, 32'd1, 32'd0};
        reset_dut(4'b1111);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done(40, d, lat);
            exp_one = 4'b0001 << k;
            check_eq($sformatf("cont_done%0d", k), 32'(d), 32'(exp_one));
            check_eq($sformatf("cont_id%0d", k), 32'(rsp_id), 32'(k));
            check_eq($sformatf("cont_res%0d", k), 32'(rsp_result), 32'(exp_res[k]));
            if (k > 0) check_eq($sformatf("cont_gap%0d", k), 32'(cyc - prev), 32'd8);
            prev = cyc;
            req = req & ~d;
        end

        // Fairness: requesters 0 and 2 hold continuously
        req_nr = {32'd0, 32'd9, 32'd0, 32'd4};
        reset_dut(4'b0101);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done(40, d, lat);
            check_eq($sformatf("fair_id%0d", k), 32'(rsp_id), 32'(fair_ids[k]));
            check_eq($sformatf("fair_res%0d", k), 32'(rsp_result), (fair_ids[k] == 0) ? 32'd2 : 32'd3);
            if (k > 0) check_eq($sformatf("fair_gap%0d", k), 32'(cyc - prev), 32'd8);
            prev = cyc;
        end
        req = 4'b0000;

        // Negative operand on requester 3, then 0x7FFFFFFF
        req_nr = {32'hFFFF_FFF7, 32'd0, 32'd0, 32'd0};
        reset_dut(4'b1000);
        wait_done(40, d, lat);
        check_eq("neg_done", 32'(d), 32'h8);
        check_eq("neg_cflag", 32'(rsp_cflag), 32'd1);
        check_eq("neg_id", 32'(rsp_id), 32'd3);
        check_eq("neg_oflag", 32'(rsp_oflag), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        req_nr[127:96] = 32'h7FFF_FFFF;
        req = 4'b1000;
        wait_done(40, d, lat);
        check_eq("big_oflag", 32'(rsp_oflag), 32'd1);
        check_eq("big_cflag", 32'(rsp_cflag), 32'd0);
        check_eq("big_result", 32'(rsp_result), 32'd46340);
        req = 4'b0000;
        @(negedge clk);

        // Reset two cycles into WAIT
        req_nr[63:32] = 32'd10000;
        req = 4'b0010;
        repeat (3) @(negedge clk);
        check_eq("mid_in_wait", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_nr", sq_nr, 32'd0);
        check_eq("mid_result", 32'(rsp_result), 32'd0);
        check_eq("mid_oflag", 32'(rsp_oflag), 32'd0);
        check_eq("mid_start", 32'(sq_start), 32'd0);
        n_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done != 4'b0000) n_done++;
        end
        check_eq("mid_no_done", 32'(n_done), 32'd0);
        rst = 1'b1;
        wait_done(40, d, lat);
        check_eq("mid_latency", 32'(lat), 32'd7);
        check_eq("mid_done", 32'(d), 32'h2);
        check_eq("mid_id", 32'(rsp_id), 32'd1);
        check_eq("mid_res", 32'(rsp_result), 32'd100);
        req = 4'b0000;

        // sqrt never answers
        m_hang = 1'b1;
        req_nr[31:0] = 32'd5;
        reset_dut(4'b0001);
`ifdef SQRT_ARB_TIMEOUT_EN
        wait_done(60, d, lat);
        check_eq("tmo_latency", 32'(lat), 32'd18);
        check_eq("tmo_done", 32'(d), 32'h1);
        check_eq("tmo_err", 32'(rsp_err), 32'd1);
        check_eq("tmo_result", 32'(rsp_result), 32'd0);
        req = 4'b0000;
        m_hang = 1'b0;
        @(negedge clk);
        req_nr[31:0] = 32'd49;
        req = 4'b0001;
        wait_done(40, d, lat);
        check_eq("tmo_clear_err", 32'(rsp_err), 32'd0);
        check_eq("tmo_next_result", 32'(rsp_result), 32'd7);
        req = 4'b0000;
`else
        n_done = 0;
        n_idle = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done != 4'b0000) n_done++;
            if (i > 0 && !busy) n_idle++;
        end
        check_eq("hang_no_done", 32'(n_done), 32'd0);
        check_eq("hang_busy", 32'(n_idle), 32'd0);
        check_eq("hang_err", 32'(rsp_err), 32'd0);
        m_hang = 1'b0;
        reset_dut(4'b0000);
`endif
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Round-robin arbiter and sequencer that shares one `sqrt` unit (32-bit operand in, 16-bit root plus `Cflag`/`Oflag` out, `start`/`ready` handshake) between `NREQ` requesters. It sits between the requesting datapath blocks and the single `sqrt` instance. It does the following:
- grants one request at a time and latches that requester's operand;
- issues a one-cycle `start` to `sqrt` and waits for `ready`;
- returns result, flags and requester ID with a one-cycle `done` pulse.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `IDW`, 2, width of `rsp_id`; must equal ceil(log2(`NREQ`)).
- `TIMEOUT_CYCLES`, 1024, watchdog limit in WAIT. Only used with `SQRT_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request. The requester holds it high until it sees its `done` bit.
- `req_nr`  in  32*NREQ  operands; requester i uses bits [32*i+31:32*i].
- `done`  out  NREQ  one-hot, one-cycle completion pulse.
- `rsp_result`  out  16  root of the completed operation.
- `rsp_cflag`  out  1  `Cflag` of the completed operation.
- `rsp_oflag`  out  1  `Oflag` of the completed operation.
- `rsp_err`  out  1  watchdog abort flag; tied 0 without the macro.
- `rsp_id`  out  IDW  index of the completed requester.
- `busy`  out  1  high in every state except IDLE.
- `sq_start`  out  1  to `sqrt.start`.
- `sq_nr`  out  32  to `sqrt.initial_nr`.
- `sq_ready`  in  1  from `sqrt.ready`.
- `sq_result`  in  16  from `sqrt.result`.
- `sq_cflag`  in  1  from `sqrt.Cflag`.
- `sq_oflag`  in  1  from `sqrt.Oflag`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- **IDLE:**
  - If `req` is nonzero, grant the first set bit at or after `ptr`, searching upward with wrap-around.
  - On grant, latch the winner's operand into `sq_nr` and its index into `cur_id`, then go to LAUNCH.
  - If `req` is zero, stay in IDLE.
- **LAUNCH:** `sq_start`=1 for exactly this cycle, then go to WAIT.
- **WAIT:**
  - `sq_start`=0.
  - When `sq_ready`=1, capture `sq_result`, `sq_cflag` and `sq_oflag` into the `rsp_*` registers, set `rsp_id`=`cur_id`, then go to RESP.
- **RESP:**
  - `done[cur_id]`=1 for this cycle only.
  - `ptr` is set to (`cur_id`+1) mod `NREQ`.
  - Go to IDLE.
- Response hold: `rsp_*` registers hold their value until the next capture. They are valid from the RESP cycle onward.
- Operand stability: `sq_nr` is constant from the LAUNCH cycle until the FSM leaves WAIT. Later changes on `req_nr` are ignored.
- Flags: `sq_cflag` and `sq_oflag` are passed through unmodified. No arithmetic is performed on operand or result. A negative operand (bit 31 set) is forwarded as-is; flagging it is `sqrt`'s job.
- Request dropped mid-operation: the operation still completes, `done` still pulses, and the response is discarded by the requester. No abort is performed.
- `req` is sampled only in IDLE. A request from the winner that is still high in the IDLE after RESP is treated as a new request and competes normally. Fairness is guaranteed by `ptr`.
- Reset (`rst`=0, at any time including mid-WAIT), asynchronously:
  - state returns to IDLE;
  - `ptr`, `cur_id`, `sq_nr`, `rsp_result`, `rsp_cflag`, `rsp_oflag`, `rsp_err` and `rsp_id` return to 0;
  - `done`, `busy` and `sq_start` return to 0.
- The operation in flight at reset is lost and no `done` is issued for it. `sqrt` shares the same reset.

## Timing
- Grant happens in IDLE (cycle 0). `sq_start` is high in cycle 1.
- `sq_ready` is ignored in LAUNCH and sampled from cycle 2 onward.
- Latency from the grant cycle to the `done` cycle is (cycles spent in WAIT) + 2.
- Minimum back-to-back spacing between grants is 4 cycles: IDLE, LAUNCH, one WAIT cycle, RESP.
- `busy` rises in the cycle after grant, together with LAUNCH, and falls when the FSM enters IDLE.

## Configuration
- Macro: `SQRT_ARB_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT, cleared on entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `sq_ready`, go to RESP with `rsp_err`=1 and `rsp_result`, `rsp_cflag` and `rsp_oflag` set to 0.
  - A normal completion sets `rsp_err`=0.
- Not defined: no counter is built, WAIT lasts until `sq_ready` indefinitely, and `rsp_err` is constant 0.

## Test plan
- Bench model: behavioural `sqrt` with 5-cycle latency.
- Single request: `req`=0001, operand 144 -> one `done`=0001 pulse in cycle 7 after grant; `rsp_result`=12, `rsp_id`=0, `rsp_cflag`=0.
- Full contention: `req`=1111 held from reset release, operands 0, 1, 65535, 2^31-2 -> `done` order 0,1,2,3; results 0, 1, 255, 46340; grants spaced 8 cycles.
- Fairness: `req`=0101 held continuously -> grants alternate 0,2,0,2; requester 2 never waits more than one operation.
- Negative operand: requester 3, operand 0xFFFFFFF7 -> `rsp_cflag`=1 and `rsp_id`=3. A second run with operand 0x7FFFFFFF -> `rsp_oflag` equals the model's `Oflag`.
- Reset mid-WAIT: pull `rst` low 2 cycles into WAIT -> all outputs 0 the same cycle and no `done`. After release with `req`=0010 held, requester 1 is served normally.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16, model never raises `ready`) -> `done` 18 cycles after grant, with `rsp_err`=1 and `rsp_result`=0. Without the macro, `busy` stays 1 for 1000 cycles with no `done`.
